// File: rtl/cla_seq_ctrl.sv
// Multi-cycle add/subtract sequencer: one 4-bit carry-lookahead slice swept LSB nibble first.
// Optional CLA_SEQ_ZERO_FLAG_EN adds a per-nibble accumulated zero flag output.

module cla_nib (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] p, g, c;
  logic       pg, gg;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign pg   = &p;
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign cout = gg | (pg & cin);
  assign s    = p ^ c;
endmodule

module cla_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int NIB_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
`ifdef CLA_SEQ_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);
  localparam int             NNIB = WIDTH / 4;
  localparam logic [NIB_W-1:0] LAST = NIB_W'(NNIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;

  logic [WIDTH-1:0] a_r, b_r, res_r;
  logic [NIB_W-1:0] nib;
  logic             carry, cout_r, ovf_r;
  logic [3:0]       sum;
  logic             c4;
  logic             accept, last;

  assign accept = in_valid & in_ready;
  assign last   = (nib == LAST);

  // Operands shift right each RUN cycle, so the active nibble is always in bits [3:0].
  cla_nib u_nib (
    .a    (a_r[3:0]),
    .b    (b_r[3:0]),
    .cin  (carry),
    .s    (sum),
    .cout (c4)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept)    nxt = RUN;
      RUN:     if (last)      nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default:                nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      res_r  <= '0;
      nib    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_r   <= a;
          b_r   <= b ^ {WIDTH{sub}};
          carry <= sub;
          nib   <= '0;
          res_r <= '0;
        end
        RUN: begin
          a_r   <= a_r >> 4;
          b_r   <= b_r >> 4;
          res_r <= res_r | (WIDTH'(sum) << {nib, 2'b00});
          carry <= c4;
          if (last) begin
            cout_r <= c4;
            // a_r/b_r[3] hold the operand MSBs during the final nibble
            ovf_r  <= (a_r[3] == b_r[3]) & (sum[3] != a_r[3]);
          end else begin
            nib <= nib + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CLA_SEQ_ZERO_FLAG_EN
  logic zero_r;
  always_ff @(posedge clk) begin
    if (rst)                         zero_r <= 1'b0;
    else if (state == IDLE && accept) zero_r <= 1'b1;
    else if (state == RUN)           zero_r <= zero_r & ~|sum;
  end
  assign zero = zero_r;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed bench for cla_seq_ctrl (WIDTH=32): arithmetic vectors, latency, hold, abort, back-to-back.
`timescale 1ns/1ps
module tb_cla_seq_ctrl;
  logic        clk = 0;
  logic        rst = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] a = 0, b = 0;
  logic        sub = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] result;
  logic        cout, ovf;
`ifdef CLA_SEQ_ZERO_FLAG_EN
  logic        zero;
`endif

  int checks = 0;
  int failures = 0;

  cla_seq_ctrl #(.WIDTH(32), .NIB_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf)
`ifdef CLA_SEQ_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  always #5 clk = ~clk;

  // Issues one request from IDLE and waits for out_valid; lat = edges from accept to out_valid.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                       output int lat);
    int guard = 0;
    while (!in_ready && guard < 30) begin @(posedge clk); #1; guard++; end
    a = ia; b = ib; sub = isub; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; sub = ~isub;
    lat = 0;
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic drain();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b result=%h cout=%b ovf=%b, want 1 0 0 0 0",
               in_ready, out_valid, result, cout, ovf);
    end
`ifdef CLA_SEQ_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b0) begin failures++; $display("FAIL reset_zero: got %b want 0", zero); end
`endif
  endtask

  // Table-driven arithmetic: each row carries its hand-computed result, cout and ovf.
  task automatic test_arith();
    logic [31:0] va [7], vb [7], er [7];
    logic        vs [7], ec [7], eo [7];
    int lat;
    va[0]=32'h0000_0005; vb[0]=32'h0000_0003; vs[0]=0; er[0]=32'h0000_0008; ec[0]=0; eo[0]=0;
    va[1]=32'hFFFF_FFFF; vb[1]=32'h0000_0001; vs[1]=0; er[1]=32'h0000_0000; ec[1]=1; eo[1]=0;
    va[2]=32'h7FFF_FFFF; vb[2]=32'hFFFF_FFFF; vs[2]=1; er[2]=32'h8000_0000; ec[2]=0; eo[2]=1;
    va[3]=32'h0000_0005; vb[3]=32'h0000_0005; vs[3]=1; er[3]=32'h0000_0000; ec[3]=1; eo[3]=0;
    va[4]=32'h1234_5678; vb[4]=32'h1111_1111; vs[4]=0; er[4]=32'h2345_6789; ec[4]=0; eo[4]=0;
    va[5]=32'h0000_0003; vb[5]=32'h0000_0005; vs[5]=1; er[5]=32'hFFFF_FFFE; ec[5]=0; eo[5]=0;
    va[6]=32'h8000_0000; vb[6]=32'h8000_0000; vs[6]=0; er[6]=32'h0000_0000; ec[6]=1; eo[6]=1;
    for (int i = 0; i < 7; i++) begin
      issue(va[i], vb[i], vs[i], lat);
      checks++;
      if (lat !== 8) begin failures++; $display("FAIL latency[%0d]: got %0d want 8", i, lat); end
      checks++;
      if (result !== er[i] || cout !== ec[i] || ovf !== eo[i]) begin
        failures++;
        $display("FAIL arith[%0d]: result=%h cout=%b ovf=%b, want %h %b %b",
                 i, result, cout, ovf, er[i], ec[i], eo[i]);
      end
`ifdef CLA_SEQ_ZERO_FLAG_EN
      checks++;
      if (zero !== (er[i] == 32'h0)) begin
        failures++; $display("FAIL zero[%0d]: got %b want %b", i, zero, er[i] == 32'h0);
      end
`endif
      drain();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL handshake[%0d]: out_valid=%b in_ready=%b, want 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    issue(32'h0000_00F0, 32'h0000_000F, 0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a = 32'h0; b = 32'h0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h0000_00FF) begin
        failures++;
        $display("FAIL hold[%0d]: out_valid=%b in_ready=%b result=%h, want 1 0 000000ff",
                 i, out_valid, in_ready, result);
      end
    end
    in_valid = 0;
    drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_abort();
    int lat;
    int seen = 0;
    a = 32'h0000_1111; b = 32'h0000_2222; sub = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL abort: in_ready=%b out_valid=%b result=%h, want 1 0 0", in_ready, out_valid, result);
    end
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL abort_pulse: out_valid cycles=%0d want 0", seen); end
    issue(32'h1, 32'h1, 0, lat);
    checks++;
    if (lat !== 8 || result !== 32'h2 || cout !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL after_abort: lat=%0d result=%h cout=%b ovf=%b, want 8 2 0 0", lat, result, cout, ovf);
    end
    drain();
  endtask

  // in_valid and out_ready held high: out_valid lasts one cycle, issue interval is 10.
  task automatic test_back_to_back();
    int guard = 0;
    a = 32'd10; b = 32'd20; sub = 0; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== (i == 8 || i == 18)) begin
        failures++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, out_valid, i == 8 || i == 18);
      end
      if (i == 8 || i == 18) begin
        checks++;
        if (result !== 32'd30) begin failures++; $display("FAIL b2b_result[%0d]: got %h want 1e", i, result); end
      end
    end
    in_valid = 0;
    while (!in_ready && guard < 30) begin @(posedge clk); #1; guard++; end
    out_ready = 0;
    checks++;
    if (!in_ready) begin failures++; $display("FAIL b2b_drain: in_ready=%b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_hold();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
